// File: rtl/axis_pkg.sv
// rtl/axis_pkg.sv - shared helpers for stream blocks
package axis_pkg;

  // Pointer width for a circular buffer of depth-1 words, never below 1 bit.
  function automatic int ptr_width(input int depth);
    return ($clog2(depth - 1) < 1) ? 1 : $clog2(depth - 1);
  endfunction

  // Advance a pointer, wrapping to 0 after 'last' (no power-of-two assumption).
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned last);
    return (ptr >= last) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/sdp_ram.sv
// rtl/sdp_ram.sv - simple dual-port RAM, one write port, one registered read port
module sdp_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 15,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clock,
  input  logic             wen,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             ren,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (wen) mem[waddr] <= wdata;
    if (ren) rdata <= mem[raddr];
  end

endmodule

// File: rtl/axis_fifo.sv
// rtl/axis_fifo.sv - stream FIFO with RAM store, registered output word and level flags
// Occupancy counts the output word plus the RAM contents.
module axis_fifo
  import axis_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 16,
  parameter int AFULL      = DEPTH - 1,
  parameter int AEMPTY     = 1,
  parameter int SIZE_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  output logic [SIZE_WIDTH-1:0] size,
  output logic                  almost_full,
  output logic                  almost_empty,
  input  logic [WIDTH-1:0]      idata,
  input  logic                  ivalid,
  output logic                  iready,
  output logic [WIDTH-1:0]      odata,
  output logic                  ovalid,
  input  logic                  oready
);

  localparam int PW = ptr_width(DEPTH);
  localparam int unsigned LAST = DEPTH - 2;
  localparam logic [SIZE_WIDTH-1:0] DEPTH_S  = SIZE_WIDTH'(DEPTH);
  localparam logic [SIZE_WIDTH-1:0] AFULL_S  = SIZE_WIDTH'(AFULL);
  localparam logic [SIZE_WIDTH-1:0] AEMPTY_S = SIZE_WIDTH'(AEMPTY);
  localparam logic AF_AT_ZERO = (AFULL <= 0);

  logic [PW-1:0]         wptr, rptr;
  logic [SIZE_WIDTH-1:0] size_next;
  logic [WIDTH-1:0]      odata_q, ram_rdata;
  logic                  from_ram;
  logic                  itransfer, otransfer, load, ram_busy;
  logic                  ram_rd, ram_wr, bypass;

  always_comb begin
    itransfer = ivalid && iready;
    otransfer = ovalid && oready;
    size_next = size + SIZE_WIDTH'(itransfer) - SIZE_WIDTH'(otransfer);
    // Output word is present whenever size > 0, so the RAM holds size-1 words.
    ram_busy  = size > SIZE_WIDTH'(1);
    load      = !ovalid || otransfer;
    ram_rd    = !flush && load && ram_busy;
    bypass    = !flush && load && !ram_busy && itransfer;
    ram_wr    = !flush && itransfer && !bypass;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      size         <= '0;
      iready       <= 1'b0;
      ovalid       <= 1'b0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      wptr         <= '0;
      rptr         <= '0;
      odata_q      <= '0;
      from_ram     <= 1'b0;
    end else if (flush) begin
      size         <= '0;
      iready       <= 1'b1;
      ovalid       <= 1'b0;
      almost_full  <= AF_AT_ZERO;
      almost_empty <= 1'b1;
      wptr         <= '0;
      rptr         <= '0;
    end else begin
      size         <= size_next;
      iready       <= size_next < DEPTH_S;
      ovalid       <= size_next != '0;
      almost_full  <= size_next >= AFULL_S;
      almost_empty <= size_next <= AEMPTY_S;
      if (ram_rd) begin
        rptr     <= PW'(ptr_inc(32'(rptr), LAST));
        from_ram <= 1'b1;
      end else if (bypass) begin
        odata_q  <= idata;
        from_ram <= 1'b0;
      end
      if (ram_wr) wptr <= PW'(ptr_inc(32'(wptr), LAST));
    end
  end

  // The RAM read register doubles as the output register when it holds the oldest word.
  assign odata = from_ram ? ram_rdata : odata_q;

  sdp_ram #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH - 1)
  ) u_ram (
    .clock(clock),
    .wen  (ram_wr),
    .waddr(wptr),
    .wdata(idata),
    .ren  (ram_rd),
    .raddr(rptr),
    .rdata(ram_rdata)
  );

endmodule

// File: doc/axis_fifo.md
# axis_fifo

Parametrised AXI-stream FIFO with a block-RAM backing store, registered output stage, occupancy count, programmable almost-full/almost-empty flags and a synchronous flush. Next generation of the small shift-register FIFO: depth is no longer limited by register cost, and ordering, handshake and latency behaviour are unchanged. Sits between stream producers and consumers wherever buffering deeper than a few words is needed, e.g. sample capture ahead of a UART or USB drain.

## Interface
- WIDTH, 8: data width in bits.
- DEPTH, 16: total capacity in words, including the output register; DEPTH >= 2, any integer, not necessarily a power of 2.
- AFULL, DEPTH-1: almost_full asserts when occupancy >= AFULL.
- AEMPTY, 1: almost_empty asserts when occupancy <= AEMPTY.
- SIZE_WIDTH, $clog2(DEPTH+1): width of the size output.

- clock  in  1  single clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of contents, one cycle.
- size  out  SIZE_WIDTH  registered occupancy, range 0..DEPTH.
- almost_full  out  1  registered threshold flag.
- almost_empty  out  1  registered threshold flag.
- idata  in  WIDTH  input word.
- ivalid  in  1  input valid.
- iready  out  1  registered input ready.
- odata  out  WIDTH  registered output word.
- ovalid  out  1  registered output valid.
- oready  in  1  output ready.

## Operation
- itransfer = ivalid && iready; otransfer = ovalid && oready.
- Storage: odata is the output register, holding the oldest word. RAM holds DEPTH-1 words as a circular buffer with wptr and rptr in 0..DEPTH-2, and explicit wrap to 0 after DEPTH-2, with no modulo-2^n assumption.
- size_next = size - otransfer + itransfer. It never leaves 0..DEPTH because iready and ovalid gate the transfers.
- Registered each cycle: size <= size_next; iready <= size_next < DEPTH; ovalid <= size_next > 0; almost_full <= size_next >= AFULL; almost_empty <= size_next <= AEMPTY.
- odata load rule, applied when the output register is empty or being emptied (size == 0, or otransfer):
  - if the RAM holds words: odata <= ram[rptr] (synchronous RAM read), rptr advances.
  - else if itransfer: odata <= idata (bypass); RAM is not written.
  - else odata holds.
- Otherwise, an itransfer writes ram[wptr] and wptr advances.
- Order is strictly preserved. The bypass applies only when the RAM is empty.
- Flush: when flush = 1, the next state is size 0, ovalid 0, iready 1, almost_full = (0 >= AFULL), almost_empty 1, and rptr = wptr = 0. Transfers in the flush cycle are discarded. odata keeps its stale value.
- Reset: asynchronous, same clear as flush except iready = 0 and odata = 0.

## Timing
- Reset values: size 0, iready 0, ovalid 0, almost_full 0, almost_empty 1, odata 0.
- iready rises on the first rising clock edge after reset deasserts.
- Latency: a word accepted at edge N into an empty FIFO is on odata with ovalid = 1 after edge N, i.e. one cycle.
- Full: iready = 0 while size == DEPTH. A simultaneous otransfer at size DEPTH restores iready the next cycle, never combinationally.
- Simultaneous itransfer and otransfer: size unchanged; at size 1 the bypass moves idata into odata with ovalid staying 1.
- Throughput: one word per cycle sustained in and out at any occupancy 1..DEPTH-1.
- Reset asserted mid-stream: outputs clear immediately, without waiting for a clock edge.
- Flush has priority over concurrent transfers. Reset has priority over flush.

## Structure
- A shared package axis_pkg holds the pointer-increment-with-wrap function and the width helper for pointers, $clog2(DEPTH-1) with a minimum of 1. Both are reused by other stream blocks.
- One sub-module, sdp_ram: simple dual-port RAM with WIDTH and DEPTH parameters, one write port, one synchronous-read port, no reset.
- Control (pointers, size, flags, odata mux) lives in axis_fifo.

## Test plan
All scenarios use WIDTH=8, DEPTH=5, AFULL=4, AEMPTY=1.
- **Reset release:** hold reset 3 cycles, then release.
  - During reset: size=0, iready=0, ovalid=0, almost_empty=1.
  - After the first edge: iready=1.
- **Fill without draining:** push 0x01..0x06 with oready=0.
  - Exactly 5 accepted; size=5, iready=0, almost_full=1 from size 4.
  - Then drain: out 0x01..0x05 in order, size back to 0.
- **Single-word latency:** push 0xA5 into an empty FIFO with oready=1.
  - ovalid=1 with odata=0xA5 one cycle after acceptance; ovalid=0 the next cycle.
- **Streaming:** ivalid=oready=1 continuously for 20 words, 0x00..0x13.
  - One word out per cycle, in order; size stays at 1.
- **RAM wrap:** random ivalid/oready at 50% for 1000 words.
  - Output sequence equals input sequence.
  - Pointers wrap at 3 without loss; size always equals accepted minus delivered.
- **Flush at size 3:** assert flush with ivalid=1 in the same cycle.
  - Next cycle: size=0, ovalid=0, iready=1.
  - The next push of 0x7E emerges as the first output.
